wb_uart_rx: RTL

WB_UART_RX -- requirements
Module: wb_uart_rx

---
 rtl/wb_uart_pkg.sv | 34 +++
 rtl/wb_uart_rx_fifo.sv | 85 ++++++++
 rtl/wb_uart_rx.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_uart_pkg.sv
// ---------------------------------------------------------------------------
// wb_uart_pkg
// Shared definitions for the Wishbone UART blocks (RX and TX).
//   - DIV_VAL_DEFAULT : bit period minus one, in clk cycles (115200 baud
//                       from the system clock).
//   - FIFO_DEPTH_DEFAULT : default receive FIFO depth.
//   - uart_state_e    : serial framing state encoding shared by RX and TX.
//   - ADDR_DATA / ADDR_STATUS : Wishbone register map (one address bit).
//   - packStatus()    : builds the STATUS register byte from its flags.
// ---------------------------------------------------------------------------
package wb_uart_pkg;

  localparam int DIV_VAL_DEFAULT    = 177;
  localparam int FIFO_DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam logic ADDR_DATA   = 1'b0;
  localparam logic ADDR_STATUS = 1'b1;

  // STATUS layout: {4'b0, overrun, frameErr, full, notEmpty}
  function automatic logic [7:0] packStatus(input logic overrun,
                                            input logic frameErr,
                                            input logic full,
                                            input logic empty);
    return {4'b0000, overrun, frameErr, full, ~empty};
  endfunction

endpackage

// File: rtl/wb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// wb_uart_rx_fifo
// Small synchronous FIFO holding received bytes until software reads them.
// Pointers wrap naturally because DEPTH is a power of two; the occupancy
// counter is one bit wider than the pointers so full and empty are distinct.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset (FIFO becomes empty)
//   push_i   in   write data_i this cycle (ignored when full unless popping)
//   pop_i    in   drop the head entry this cycle (ignored when empty)
//   data_i   in   byte to write
//   data_o   out  current head entry (meaningless when empty_o)
//   full_o   out  FIFO holds DEPTH entries
//   empty_o  out  FIFO holds no entries
// ---------------------------------------------------------------------------
module wb_uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [AW:0]      count_q, count_d;
  logic             doPush;
  logic             doPop;

  // A pop on a full FIFO frees a slot in the same cycle, so a simultaneous
  // push is still accepted and the occupancy stays unchanged.
  always_comb begin
    doPop   = pop_i && (count_q != '0);
    doPush  = push_i && ((count_q != FullCount) || doPop);
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (doPop) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    if (doPush && !doPop) begin
      count_d = count_q + 1'b1;
    end else if (!doPush && doPop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rdPtr_q];
  assign full_o  = (count_q == FullCount);
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/wb_uart_rx.sv
// ---------------------------------------------------------------------------
// wb_uart_rx
// 8N1 UART receiver with a small receive FIFO behind a Wishbone slave.
// The serial line is synchronised, framed by a mid-bit sampling FSM, and
// completed bytes are queued.  Software reads DATA to pop the queue and
// STATUS to read (and clear) the sticky error flags.
//
// Parameters
//   DIV_VAL     bit period minus one, in clk cycles
//   FIFO_DEPTH  receive FIFO entries (power of two, >= 2)
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   i_wb_cyc   in   Wishbone cycle
//   i_wb_stb   in   Wishbone strobe
//   i_wb_we    in   Wishbone write enable (writes are acked and ignored)
//   i_wb_addr  in   0 = DATA, 1 = STATUS
//   o_wb_data  out  read data, valid while o_wb_ack is high
//   o_wb_ack   out  one-cycle acknowledge per access
//   uart_rx    in   serial line, idle high, LSB first
//   o_rx_irq   out  high while the FIFO holds at least one byte
// ---------------------------------------------------------------------------
module wb_uart_rx
  import wb_uart_pkg::*;
#(
  parameter int DIV_VAL    = DIV_VAL_DEFAULT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_wb_cyc,
  input  logic       i_wb_stb,
  input  logic       i_wb_we,
  input  logic       i_wb_addr,
  output logic [7:0] o_wb_data,
  output logic       o_wb_ack,
  input  logic       uart_rx,
  output logic       o_rx_irq
);

  localparam int CW = $clog2(DIV_VAL + 1);
  localparam logic [CW-1:0] DivLast = CW'(DIV_VAL);
  localparam logic [CW-1:0] DivHalf = CW'(DIV_VAL / 2);

  // Serial side
  logic            rxMeta_q;
  logic            rxS_q;
  uart_state_e     state_q, state_d;
  logic [CW-1:0]   divCnt_q, divCnt_d;
  logic [2:0]      bitIdx_q, bitIdx_d;
  logic [7:0]      shift_q, shift_d;
  logic            pushReq;
  logic            frameErrSet;

  // Bus side
  logic            ack_q, ack_d;
  logic [7:0]      wbData_q, wbData_d;
  logic            overrun_q, overrun_d;
  logic            frameErr_q, frameErr_d;
  logic            wbReq;
  logic            dataRead;
  logic            statusRead;
  logic            overrunSet;

  // FIFO
  logic            fifoPop;
  logic [7:0]      fifoData;
  logic            fifoFull;
  logic            fifoEmpty;

  // Two-flop synchroniser; resets to the idle (high) line level so a reset
  // release never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxMeta_q <= 1'b1;
      rxS_q    <= 1'b1;
    end else begin
      rxMeta_q <= uart_rx;
      rxS_q    <= rxMeta_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      divCnt_q <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
    end else begin
      state_q  <= state_d;
      divCnt_q <= divCnt_d;
      bitIdx_q <= bitIdx_d;
      shift_q  <= shift_d;
    end
  end

  // START waits half a bit to re-check the line in the middle of the start
  // bit (glitch reject); after that every sample lands mid-bit because DATA
  // and STOP wait a full bit period each.  Bits shift in from the top so the
  // first bit received ends up in bit 0.
  always_comb begin
    state_d     = state_q;
    divCnt_d    = divCnt_q;
    bitIdx_d    = bitIdx_q;
    shift_d     = shift_q;
    pushReq     = 1'b0;
    frameErrSet = 1'b0;
    case (state_q)
      ST_IDLE: begin
        divCnt_d = '0;
        bitIdx_d = '0;
        if (!rxS_q) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (divCnt_q == DivHalf) begin
          divCnt_d = '0;
          state_d  = rxS_q ? ST_IDLE : ST_DATA;
        end else begin
          divCnt_d = divCnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (divCnt_q == DivLast) begin
          divCnt_d = '0;
          shift_d  = {rxS_q, shift_q[7:1]};
          bitIdx_d = bitIdx_q + 1'b1;
          if (bitIdx_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end else begin
          divCnt_d = divCnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (divCnt_q == DivLast) begin
          divCnt_d = '0;
          state_d  = ST_IDLE;
          if (rxS_q) begin
            pushReq = 1'b1;
          end else begin
            frameErrSet = 1'b1;
          end
        end else begin
          divCnt_d = divCnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  wb_uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (pushReq),
    .pop_i   (fifoPop),
    .data_i  (shift_q),
    .data_o  (fifoData),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  // A request is taken on the cycle it is first seen and acked on the next,
  // so the read side effects (pop, flag clear) happen on the same edge that
  // captures o_wb_data.  A flag that sets on that same edge wins over the
  // clear so no error event is ever lost.
  always_comb begin
    wbReq      = i_wb_cyc & i_wb_stb & ~ack_q;
    dataRead   = wbReq & ~i_wb_we & (i_wb_addr == ADDR_DATA);
    statusRead = wbReq & ~i_wb_we & (i_wb_addr == ADDR_STATUS);
    fifoPop    = dataRead & ~fifoEmpty;
    overrunSet = pushReq & fifoFull & ~fifoPop;
    ack_d      = wbReq;
    wbData_d   = wbData_q;
    if (dataRead) begin
      wbData_d = fifoEmpty ? 8'h00 : fifoData;
    end else if (statusRead) begin
      wbData_d = packStatus(overrun_q, frameErr_q, fifoFull, fifoEmpty);
    end else if (wbReq) begin
      wbData_d = 8'h00;
    end
    overrun_d  = overrunSet  | (overrun_q  & ~statusRead);
    frameErr_d = frameErrSet | (frameErr_q & ~statusRead);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q      <= 1'b0;
      wbData_q   <= 8'h00;
      overrun_q  <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      ack_q      <= ack_d;
      wbData_q   <= wbData_d;
      overrun_q  <= overrun_d;
      frameErr_q <= frameErr_d;
    end
  end

  assign o_wb_ack  = ack_q;
  assign o_wb_data = wbData_q;
  assign o_rx_irq  = ~fifoEmpty;

endmodule
